// File: rtl/seg_serial_driver.sv
// Serialises a segment pattern into cascaded 7-segment shift registers.
// The pattern is sent MSB first, followed by a latch strobe and a one-cycle done pulse.
module seg_serial_driver #(
    parameter int DIV   = 2,
    parameter int NBITS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] seg_txt,
    output logic             seg_clk,
    output logic             seg_sout,
    output logic             seg_latch,
    output logic             seg_clrn,
    output logic             busy,
    output logic             done
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             phase_q, phase_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic             pending_q, pending_d;
    logic             seg_clk_q, seg_clk_d;
    logic             seg_sout_q, seg_sout_d;
    logic             seg_latch_q, seg_latch_d;
    logic             seg_clrn_q, seg_clrn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_last;
    logic             capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            phase_q     <= 1'b0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            pending_q   <= 1'b0;
            seg_clk_q   <= 1'b0;
            seg_sout_q  <= 1'b0;
            seg_latch_q <= 1'b0;
            seg_clrn_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            pending_q   <= pending_d;
            seg_clk_q   <= seg_clk_d;
            seg_sout_q  <= seg_sout_d;
            seg_latch_q <= seg_latch_d;
            seg_clrn_q  <= seg_clrn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        pending_d  = pending_q;
        seg_sout_d = seg_sout_q;
        seg_clrn_d = 1'b1;
        done_d     = 1'b0;
        capture    = 1'b0;
        div_last   = (div_cnt_q == DIV_LAST);

        unique case (state_q)
            IDLE: begin
                if (start) capture = 1'b1;
            end
            SHIFT: begin
                pending_d = pending_q | start;
                if (div_last) begin
                    div_cnt_d = '0;
                    phase_d   = ~phase_q;
                    // End of the high half closes the bit.
                    if (phase_q) begin
                        shreg_d = {shreg_q[NBITS-2:0], 1'b0};
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = LATCH;
                        end else begin
                            bit_cnt_d  = bit_cnt_q + BW'(1);
                            seg_sout_d = shreg_q[NBITS-2];
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            LATCH: begin
                pending_d = pending_q | start;
                if (div_last) begin
                    div_cnt_d = '0;
                    done_d    = 1'b1;
                    if (pending_q || start) capture = 1'b1;
                    else state_d = IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture snapshots the pattern so later upstream changes cannot tear the display.
        if (capture) begin
            state_d    = SHIFT;
            shreg_d    = seg_txt;
            bit_cnt_d  = '0;
            div_cnt_d  = '0;
            phase_d    = 1'b0;
            pending_d  = 1'b0;
            seg_sout_d = seg_txt[NBITS-1];
        end

        seg_clk_d   = (state_d == SHIFT) && phase_d;
        seg_latch_d = (state_d == LATCH);
        busy_d      = (state_d != IDLE);
    end

    assign seg_clk   = seg_clk_q;
    assign seg_sout  = seg_sout_q;
    assign seg_latch = seg_latch_q;
    assign seg_clrn  = seg_clrn_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seg_serial_driver.sv
// Bench for seg_serial_driver: a DIV=2 instance checked through a bit scoreboard,
// plus a DIV=1 instance for the fast-clock variant.
module tb_seg_serial_driver;
    localparam int NBITS = 64;
    localparam int DIV0  = 2;
    localparam int DIV1  = 1;

    logic             clk;
    logic             rst;
    logic             start0, start1;
    logic [NBITS-1:0] txt0, txt1;
    logic seg_clk0, seg_sout0, seg_latch0, seg_clrn0, busy0, done0;
    logic seg_clk1, seg_sout1, seg_latch1, seg_clrn1, busy1, done1;

    logic [0:0] exp_q[$];
    int         checks;
    int         errors;
    int         mon_rises;

    seg_serial_driver #(.DIV(DIV0), .NBITS(NBITS)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .seg_txt(txt0),
        .seg_clk(seg_clk0), .seg_sout(seg_sout0), .seg_latch(seg_latch0),
        .seg_clrn(seg_clrn0), .busy(busy0), .done(done0)
    );

    seg_serial_driver #(.DIV(DIV1), .NBITS(NBITS)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .seg_txt(txt1),
        .seg_clk(seg_clk1), .seg_sout(seg_sout1), .seg_latch(seg_latch1),
        .seg_clrn(seg_clrn1), .busy(busy1), .done(done1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_pattern(input logic [NBITS-1:0] p);
        for (int i = NBITS - 1; i >= 0; i--) exp_q.push_back(p[i]);
    endtask

    // Pops one expected bit per seg_clk rising edge of u_dut0.
    task automatic scoreboard_monitor();
        logic       prev_clk;
        logic [0:0] exp_bit;
        int         cyc, last_rise, bit_idx;
        prev_clk = 1'b0; cyc = 0; last_rise = 0; bit_idx = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (seg_clk0 && !prev_clk) begin
                mon_rises++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_rise: got rise at cycle %0d, expected none", cyc);
                end else begin
                    exp_bit = exp_q.pop_front();
                    if (seg_sout0 !== exp_bit[0]) begin
                        errors++;
                        $display("FAIL sb_sout bit %0d: got %b expected %b", bit_idx, seg_sout0, exp_bit[0]);
                    end
                end
                if (bit_idx > 0) begin
                    checks++;
                    if (cyc - last_rise != 2 * DIV0) begin
                        errors++;
                        $display("FAIL sb_rise_gap: got %0d expected %0d", cyc - last_rise, 2 * DIV0);
                    end
                end
                last_rise = cyc;
                bit_idx++;
            end
            if (done0) begin
                checks++;
                if (bit_idx != NBITS) begin
                    errors++;
                    $display("FAIL sb_bits_per_xfer: got %0d expected %0d", bit_idx, NBITS);
                end
            end
            if (done0 || !busy0) bit_idx = 0;
            prev_clk = seg_clk0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({seg_clk0, seg_sout0, seg_latch0, seg_clrn0, busy0, done0} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {seg_clk0, seg_sout0, seg_latch0, seg_clrn0, busy0, done0});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (seg_clrn0 !== 1'b0) begin
            errors++;
            $display("FAIL clrn_before_edge: got %b expected 0", seg_clrn0);
        end
        @(negedge clk);
        checks++;
        if (seg_clrn0 !== 1'b1 || seg_clrn1 !== 1'b1) begin
            errors++;
            $display("FAIL clrn_after_edge: got %b%b expected 11", seg_clrn0, seg_clrn1);
        end
        checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_reset: got %b%b expected 00", busy0, busy1);
        end
        // asynchronous reset in the middle of a transfer
        txt0 = '1; start0 = 1'b1; push_pattern('1);
        @(negedge clk); start0 = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (busy0 !== 1'b1 || seg_sout0 !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_abort: got busy=%b sout=%b expected 1 1", busy0, seg_sout0);
        end
        @(posedge clk); #2; rst = 1'b1; #1;
        checks++;
        if ({seg_clk0, seg_sout0, seg_latch0, seg_clrn0, busy0, done0} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async: got %b expected 000000",
                     {seg_clk0, seg_sout0, seg_latch0, seg_clrn0, busy0, done0});
        end
        exp_q.delete();
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (seg_clrn0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got clrn=%b busy=%b expected 1 0", seg_clrn0, busy0);
        end
    endtask

    task automatic test_single();
        int busy_n = 0, done_n = 0, done_cyc = 0, latch_n = 0, first_latch = 0, r0;
        logic first_busy = 1'b0;
        r0 = mon_rises;
        txt0 = 64'hF0F0_0000_FFFF_A5A5; start0 = 1'b1; push_pattern(txt0);
        @(negedge clk); start0 = 1'b0;
        for (int n = 1; n <= 270; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 1) first_busy = busy0;
            if (busy0) busy_n++;
            if (done0) begin done_n++; done_cyc = n; end
            if (seg_latch0) begin latch_n++; if (first_latch == 0) first_latch = n; end
        end
        checks++;
        if (first_busy !== 1'b1) begin errors++; $display("FAIL single_busy_first: got %b expected 1", first_busy); end
        checks++;
        if (busy_n != 258) begin errors++; $display("FAIL single_busy_len: got %0d expected 258", busy_n); end
        checks++;
        if (done_n != 1 || done_cyc != 259) begin
            errors++; $display("FAIL single_done: got %0d pulses at %0d expected 1 at 259", done_n, done_cyc);
        end
        checks++;
        if (latch_n != 2 || first_latch != 257) begin
            errors++; $display("FAIL single_latch: got %0d cycles from %0d expected 2 from 257", latch_n, first_latch);
        end
        checks++;
        if (mon_rises - r0 != 64 || exp_q.size() != 0) begin
            errors++; $display("FAIL single_rises: got %0d left %0d expected 64 left 0", mon_rises - r0, exp_q.size());
        end
    endtask

    task automatic test_snapshot();
        int done_cyc = 0, r0;
        r0 = mon_rises;
        txt0 = 64'h0123_4567_89AB_CDEF; start0 = 1'b1; push_pattern(txt0);
        @(negedge clk); start0 = 1'b0;
        for (int n = 1; n <= 270; n++) begin
            if (n > 1) @(negedge clk);
            if (done0) done_cyc = n;
            txt0 = {$urandom, $urandom};
        end
        checks++;
        if (done_cyc != 259) begin errors++; $display("FAIL snap_done: got %0d expected 259", done_cyc); end
        checks++;
        if (mon_rises - r0 != 64 || exp_q.size() != 0) begin
            errors++; $display("FAIL snap_rises: got %0d left %0d expected 64 left 0", mon_rises - r0, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int busy_in = 0, busy_n = 0, done_n = 0, done_first = 0, done_last = 0, r0;
        r0 = mon_rises;
        txt0 = 64'hDEAD_BEEF_0BAD_F00D; start0 = 1'b1; push_pattern(txt0);
        @(negedge clk); start0 = 1'b0;
        for (int n = 1; n <= 540; n++) begin
            if (n > 1) @(negedge clk);
            if (busy0) begin busy_n++; if (n <= 516) busy_in++; end
            if (done0) begin done_n++; done_last = n; if (done_first == 0) done_first = n; end
            start0 = (n == 50 || n == 100);
            if (n == 258) begin txt0 = 64'h1; push_pattern(txt0); end
            else txt0 = {$urandom, $urandom};
        end
        checks++;
        if (busy_in != 516 || busy_n != 516) begin
            errors++; $display("FAIL b2b_busy: got %0d/%0d expected 516/516", busy_in, busy_n);
        end
        checks++;
        if (done_n != 2 || done_first != 259 || done_last != 517) begin
            errors++; $display("FAIL b2b_done: got %0d at %0d,%0d expected 2 at 259,517", done_n, done_first, done_last);
        end
        checks++;
        if (mon_rises - r0 != 128 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_rises: got %0d left %0d expected 128 left 0", mon_rises - r0, exp_q.size());
        end
    endtask

    task automatic test_abort();
        int latch_n = 0, done_n = 0, busy_n = 0, done_cyc = 0, r0;
        txt0 = 64'hCAFE_F00D_1234_5678; start0 = 1'b1; push_pattern(txt0);
        @(negedge clk); start0 = 1'b0;
        for (int n = 1; n <= 41; n++) begin
            if (n > 1) @(negedge clk);
            if (seg_latch0) latch_n++;
            start0 = (n == 30);
        end
        checks++;
        if (exp_q.size() != 54) begin errors++; $display("FAIL abort_bits_sent: got %0d left expected 54", exp_q.size()); end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk); rst = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (seg_latch0) latch_n++;
            if (done0) done_n++;
            if (busy0) busy_n++;
        end
        checks++;
        if (latch_n != 0 || done_n != 0 || busy_n != 0) begin
            errors++; $display("FAIL abort_quiet: got latch=%0d done=%0d busy=%0d expected 0 0 0", latch_n, done_n, busy_n);
        end
        r0 = mon_rises;
        busy_n = 0;
        txt0 = 64'h5A5A_0F0F_8001_7FFE; start0 = 1'b1; push_pattern(txt0);
        @(negedge clk); start0 = 1'b0;
        for (int n = 1; n <= 270; n++) begin
            if (n > 1) @(negedge clk);
            if (busy0) busy_n++;
            if (done0) done_cyc = n;
        end
        checks++;
        if (busy_n != 258 || done_cyc != 259) begin
            errors++; $display("FAIL abort_fresh: got busy=%0d done@%0d expected 258 259", busy_n, done_cyc);
        end
        checks++;
        if (mon_rises - r0 != 64 || exp_q.size() != 0) begin
            errors++; $display("FAIL abort_fresh_rises: got %0d left %0d expected 64 left 0", mon_rises - r0, exp_q.size());
        end
    endtask

    task automatic test_div1();
        int busy_n = 0, done_cyc = 0, latch_n = 0, rises = 0, last_rise = 0, first_rise = 0;
        logic prev;
        prev = seg_clk1;
        txt1 = '1; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int n = 1; n <= 140; n++) begin
            if (n > 1) @(negedge clk);
            if (busy1) busy_n++;
            if (done1) done_cyc = n;
            if (seg_latch1) latch_n++;
            if (seg_clk1 && !prev) begin
                rises++;
                if (first_rise == 0) first_rise = n;
                checks++;
                if (seg_sout1 !== 1'b1) begin errors++; $display("FAIL div1_sout: got %b expected 1", seg_sout1); end
                if (rises > 1) begin
                    checks++;
                    if (n - last_rise != 2) begin errors++; $display("FAIL div1_gap: got %0d expected 2", n - last_rise); end
                end
                last_rise = n;
            end
            prev = seg_clk1;
        end
        checks++;
        if (rises != 64 || first_rise != 2) begin
            errors++; $display("FAIL div1_rises: got %0d first@%0d expected 64 first@2", rises, first_rise);
        end
        checks++;
        if (busy_n != 129 || done_cyc != 130 || latch_n != 1) begin
            errors++; $display("FAIL div1_timing: got busy=%0d done@%0d latch=%0d expected 129 130 1", busy_n, done_cyc, latch_n);
        end
    endtask

    initial begin
        checks = 0; errors = 0; mon_rises = 0;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; txt0 = '0; txt1 = '0;
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_single();
        test_snapshot();
        test_back_to_back();
        test_abort();
        test_div1();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_serial_driver.md
Name: seg_serial_driver

Overview:
- Consumes the 64-bit segment pattern from the hex-to-segment stage and shifts it serially into the board's cascaded 7-segment shift registers.
- Drives shift clock, serial data and latch strobe.
- Snapshots the pattern on a start request, so upstream changes during a transfer cannot tear the display.
- Sits between the hex-to-segment stage and the top-level display pins.

Parameters:
DIV, 2, half-period of seg_clk in clk cycles (≥1)
NBITS, 64, pattern width shifted per transfer

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  transfer request, sampled on rising clk
seg_txt  input  NBITS  segment pattern (bit 63 = digit 0 segment a … bit 0 = digit 7 point)
seg_clk  output  1  shift clock to display shift registers
seg_sout  output  1  serial data, valid across seg_clk rising edge
seg_latch  output  1  output-latch strobe, active-high
seg_clrn  output  1  shift-register clear, active-low
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at transfer completion

Behaviour:
- Reset (async, rst=1), all outputs registered:
  - seg_clk=0, seg_sout=0, seg_latch=0, seg_clrn=0, busy=0, done=0.
  - Pending flag cleared; FSM in IDLE.
  - seg_clrn goes 1 on the first clk edge after rst deasserts and stays 1.
- Reset mid-transfer aborts immediately with the values above. No latch pulse is emitted.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - seg_clk=0, seg_latch=0, busy=0.
  - On an edge with start=1, capture seg_txt into the shift register, set bit counter=0, enter SHIFT. busy=1 from that edge.
- SHIFT: each bit lasts 2*DIV cycles.
  - seg_sout = current MSB of the snapshot (bit 63 first, bit 0 last).
  - seg_clk=0 for the first DIV cycles, then 1 for DIV cycles. Data is stable DIV cycles before and after the rising edge.
  - At the end of each bit, shift the snapshot left by 1 and increment the bit counter.
  - After bit NBITS-1 completes, enter LATCH.
- LATCH:
  - seg_clk=0, seg_sout holds its last value, seg_latch=1 for DIV cycles.
  - At the end of LATCH: seg_latch=0 and done=1 for exactly one cycle. That cycle is also the first cycle of the next state.
- Busy time: NBITS*2*DIV + DIV cycles. With defaults this is 258 cycles, with done in cycle 259 counted from the start edge.
- start while busy:
  - Sets the pending flag; multiple requests collapse into one.
  - At the LATCH exit edge, if pending=1 or start=1: recapture seg_txt, clear pending, go directly to SHIFT. busy stays 1, and done still pulses.
  - Otherwise go to IDLE.
- seg_txt is ignored except at capture edges.
- Counters: the divider counter is a modulo-DIV counter. The bit counter is wide enough for NBITS-1 and must not wrap mid-transfer.

Test Plan:
- Reset check: assert rst mid-cycle, no clk edge → all outputs at reset values at once. Deassert → seg_clrn=1 after the first edge; busy=0.
- Single transfer: DIV=2, seg_txt=64'hF0F0_0000_FFFF_A5A5, one start pulse.
  - Exactly 64 seg_clk rising edges, each 4 cycles apart.
  - Sampled seg_sout reproduces the pattern MSB first.
  - seg_latch high 2 cycles after the last bit; busy high 258 cycles; done one cycle at cycle 259.
- Snapshot integrity: start with seg_txt=64'h0123_4567_89AB_CDEF, then toggle seg_txt every cycle during the transfer → shifted data equals the captured value.
- Pending request: pulse start twice during a transfer, with seg_txt=64'h1 at the LATCH exit.
  - Exactly one back-to-back second transfer shifting 64'h1; busy never drops.
  - Two done pulses total.
- Abort: assert rst after 10 bits → seg_latch never pulses, pending is lost. Then a fresh start → full 64-bit transfer.
- DIV=1 variant: seg_txt all ones → 64 seg_clk edges, 2 cycles apart; busy 129 cycles; done in cycle 130.
